// File: rtl/seq_accumulator.sv
// Multi-cycle accumulator: sums a run of len operands (mod 2^N, sticky carry)
// and pulses load_out for one cycle so the downstream register captures sum_out.
module seq_accumulator #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic [N-1:0]     sum_out,
    output logic             carry_out,
    output logic             load_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, EMIT = 2'd2} state_t;

    state_t           state;
    logic [N-1:0]     acc;
    logic [CNT_W-1:0] remaining;
    logic             carry;
    logic [N:0]       add;
    logic             new_carry;

    assign add       = {1'b0, acc} + {1'b0, in_data};
    assign new_carry = carry | add[N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            carry     <= 1'b0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            acc       <= '0;
                            carry     <= 1'b0;
                            remaining <= len;
                            state     <= ACCUM;
                        end else begin
                            // empty run still produces one load of a zero result
                            sum_out   <= '0;
                            carry_out <= 1'b0;
                            state     <= EMIT;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc       <= add[N-1:0];
                        carry     <= new_carry;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            sum_out   <= add[N-1:0];
                            carry_out <= new_carry;
                            state     <= EMIT;
                        end
                    end
                end
                EMIT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Pure decodes of the state register, so load_out cannot glitch.
    assign in_ready = (state == ACCUM);
    assign busy     = (state == ACCUM) || (state == EMIT);
    assign load_out = (state == EMIT);
    assign done     = load_out;

endmodule

// File: tb/tb_seq_accumulator.sv
// Directed bench for seq_accumulator: operand-list model checked every cycle,
// plus literal expectations and a downstream register capturing on load_out.
module tb_seq_accumulator;
    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_ready;
    logic [N-1:0]     sum_out;
    logic             carry_out;
    logic             load_out;
    logic             busy;
    logic             done;

    seq_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .sum_out(sum_out), .carry_out(carry_out), .load_out(load_out),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 collecting operands, 2 presenting result.
    int m_phase = 0;
    int m_need  = 0;
    int m_sum   = 0;
    int m_carry = 0;
    int ops[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_sum   = 0;
            m_carry = 0;
            ops.delete();
        end else begin
            case (m_phase)
                0: if (start === 1'b1) begin
                    if (len == 0) begin
                        m_sum = 0; m_carry = 0; m_phase = 2;
                    end else begin
                        ops.delete(); m_need = int'(len); m_phase = 1;
                    end
                end
                1: if (in_valid === 1'b1) begin
                    ops.push_back(int'(in_data));
                    if (ops.size() == m_need) begin
                        int r;
                        int c;
                        r = 0; c = 0;
                        foreach (ops[i]) begin
                            r += ops[i];
                            if (r >= (1 << N)) begin r -= (1 << N); c = 1; end
                        end
                        m_sum = r; m_carry = c; m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  32'(in_ready),  32'(m_phase == 1));
        chk("busy",      32'(busy),      32'(m_phase != 0));
        chk("load_out",  32'(load_out),  32'(m_phase == 2));
        chk("done",      32'(done),      32'(m_phase == 2));
        chk("sum_out",   32'(sum_out),   32'(m_sum));
        chk("carry_out", 32'(carry_out), 32'(m_carry));
    end

    // Downstream register and load-pulse bookkeeping.
    logic [N-1:0] dreg = '0;
    logic         prev_load = 1'b0;
    int           pulses = 0;
    always @(posedge clk) begin
        if (load_out === 1'b1) begin
            dreg <= sum_out;
            pulses++;
            if (prev_load) begin
                n_chk++; n_fail++;
                $display("FAIL load_consecutive: load_out high two cycles at %0t", $time);
            end
        end
        prev_load <= load_out;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int l);
        start = 1'b1; len = CNT_W'(l);
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int d);
        in_valid = 1'b1; in_data = N'(d);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        step(); step();
        reset = 1'b0;
        repeat (5) step();

        // Basic run of three operands, valid held high
        do_start(3);
        feed(8'h10); feed(8'h20); feed(8'h05);
        chk("run1_load", 32'(load_out), 32'd1);
        chk("run1_sum",  32'(sum_out),  32'h35);
        chk("run1_cy",   32'(carry_out), 32'd0);
        step();
        chk("run1_dreg", 32'(dreg), 32'h35);
        chk("run1_idle", 32'(busy), 32'd0);

        // Wrap with carry, then back-to-back run clearing the sticky carry
        do_start(2);
        feed(8'hF0); feed(8'h20);
        chk("run2_sum", 32'(sum_out),   32'h10);
        chk("run2_cy",  32'(carry_out), 32'd1);
        step();
        do_start(1);
        feed(8'h01);
        chk("run3_sum", 32'(sum_out),   32'h01);
        chk("run3_cy",  32'(carry_out), 32'd0);
        step();

        // Stalls between transfers
        do_start(2);
        feed(8'h33);
        step(); step();
        chk("stall_wait", 32'(load_out), 32'd0);
        feed(8'h44);
        chk("stall_load", 32'(load_out), 32'd1);
        chk("stall_sum",  32'(sum_out),  32'h77);
        step();
        chk("stall_dreg", 32'(dreg), 32'h77);

        // Empty run
        do_start(0);
        chk("len0_load", 32'(load_out), 32'd1);
        chk("len0_sum",  32'(sum_out),  32'h00);
        step();
        chk("len0_dreg", 32'(dreg), 32'h00);

        // start/len asserted again mid-run must be ignored
        do_start(2);
        start = 1'b1; len = CNT_W'(5);
        feed(8'h08);
        start = 1'b1;
        feed(8'h09);
        start = 1'b0;
        chk("restart_load", 32'(load_out), 32'd1);
        chk("restart_sum",  32'(sum_out),  32'h11);
        step();

        // Reset after one of three transfers
        do_start(3);
        feed(8'h11);
        reset = 1'b1;
        #1;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_sum",   32'(sum_out),  32'd0);
        chk("rst_load",  32'(load_out), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Fresh run ending exactly at 2^N
        do_start(2);
        feed(8'h7F); feed(8'h81);
        chk("edge_sum", 32'(sum_out),   32'h00);
        chk("edge_cy",  32'(carry_out), 32'd1);
        step();

        // Longest run: 17*(1..15) = 0x7F8
        do_start(15);
        for (int i = 1; i <= 15; i++) feed(17 * i);
        chk("max_sum", 32'(sum_out),   32'hF8);
        chk("max_cy",  32'(carry_out), 32'd1);
        step();
        chk("max_dreg", 32'(dreg), 32'hF8);
        repeat (3) step();

        chk("pulse_count", 32'(pulses), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
